// File: rtl/seq_detect_ctrl_pkg.sv
// Shared definitions for the programmable serial sequence detector:
// state encoding, reset-default pattern/length and the length-field width rule.
package seq_detect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [15:0] DEF_PAT = 16'b1011;
    localparam int          DEF_LEN = 4;

    // Length field must hold 0..pat_w inclusive.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_match_core.sv
// Shift window, fill tracking and length-masked pattern compare.
// zout is combinational so a match is flagged in the same cycle the bit is accepted.
module seq_match_core
    import seq_detect_ctrl_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = len_width(8)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             acc,
    input  logic             xin,
    input  logic             clr,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             overlap,
    output logic             zout
);

    logic [PAT_W-1:0] window_q, window_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [PAT_W:0]   cand;
    logic [PAT_W:0]   mask;
    logic [LEN_W:0]   fill_inc;
    logic             hit;

    always_comb begin
        cand = {window_q, xin};
        mask = '0;
        for (int i = 0; i <= PAT_W; i++) begin
            mask[i] = (i < int'(len));
        end
        hit      = ((cand ^ {1'b0, pattern}) & mask) == '0;
        zout     = acc & (fill_q >= (len - LEN_W'(1))) & hit;
        fill_inc = {1'b0, fill_q} + (LEN_W + 1)'(1);

        window_d = window_q;
        fill_d   = fill_q;
        if (clr) begin
            window_d = '0;
            fill_d   = '0;
        end else if (acc) begin
            // Non-overlapping mode restarts the search from empty after a hit.
            if (zout && !overlap) begin
                window_d = '0;
                fill_d   = '0;
            end else begin
                window_d = {window_q[PAT_W-2:0], xin};
                fill_d   = (fill_inc > {1'b0, len}) ? len : fill_inc[LEN_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q <= '0;
            fill_q   <= '0;
        end else begin
            window_q <= window_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable sequence detector controller: config registers, run/done FSM,
// valid/ready pacing of the serial input and a saturating match counter.
module seq_detect_ctrl
    import seq_detect_ctrl_pkg::*;
#(
    parameter int               PAT_W       = 8,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = PAT_W'(DEF_PAT),
    parameter int               DEFAULT_LEN = DEF_LEN,
    localparam int              LEN_W       = len_width(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             stop,
    input  logic             xin_valid,
    input  logic             xin,
    output logic             xin_ready,
    output logic             zout,
    output logic [CNT_W-1:0] match_cnt,
    output logic             busy,
    output logic             done
);

    state_e           state_q;
    logic [PAT_W-1:0] pattern_q;
    logic [LEN_W-1:0] len_q, len_d;
    logic             overlap_q;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q;
    logic             done_q;
    logic             arm;
    logic             acc;
    logic             hit;

    assign arm       = start & ~stop & (state_q != ST_RUN);
    assign xin_ready = (state_q == ST_RUN) & ~stop;
    assign acc       = xin_valid & xin_ready;
    assign cnt_d     = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        len_d = cfg_len;
        if (cfg_len == '0) begin
            len_d = LEN_W'(1);
        end else if (cfg_len > LEN_W'(PAT_W)) begin
            len_d = LEN_W'(PAT_W);
        end
    end

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .acc     (acc),
        .xin     (xin),
        .clr     (arm),
        .pattern (pattern_q),
        .len     (len_q),
        .overlap (overlap_q),
        .zout    (hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= DEFAULT_PAT;
            len_q     <= LEN_W'(DEFAULT_LEN);
            overlap_q <= 1'b1;
            target_q  <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cfg_we && state_q == ST_IDLE) begin
                pattern_q <= cfg_pattern;
                len_q     <= len_d;
                overlap_q <= cfg_overlap;
                target_q  <= cfg_target;
            end
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                    end else if (start) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (hit) begin
                        cnt_q <= cnt_d;
                        // A zero target means run until stopped.
                        if (target_q != '0 && cnt_d == target_q) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign zout      = hit;
    assign match_cnt = cnt_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
